// File: rtl/cgra_pwr_seq.sv
`default_nettype none
// ============================================================================
// Module      : cgra_pwr_seq
// Description : CGRA power-domain sequencer. Ramps a segmented power-switch
//               chain one segment at a time and waits for the end-of-chain ack.
//               It then lets the rail settle, releases isolation and reports
//               the domain as on. Dropping the request isolates the domain
//               first and then opens every switch at once.
//               Optional macro CGRA_PWR_SEQ_TIMEOUT_EN bounds the wait for the
//               chain ack and raises a sticky error flag when that bound expires.
// Revision    : 1.0 - initial release
// ============================================================================
module cgra_pwr_seq #(
    parameter int NSTAGE      = 4,
    parameter int STAGE_DLY   = 3,
    parameter int SETTLE_CYC  = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pwr_on_req_i,
    output logic [NSTAGE-1:0] sw_en_o,
    input  logic              sw_ack_i,
    output logic              iso_o,
    output logic              pwr_ack_o,
    output logic              err_o
);

    // Counter must hold the largest reload value (max - 1) without wrapping.
    localparam int c_MAX_A  = (STAGE_DLY > SETTLE_CYC) ? STAGE_DLY : SETTLE_CYC;
    localparam int c_MAX    = (c_MAX_A > TIMEOUT_CYC) ? c_MAX_A : TIMEOUT_CYC;
    localparam int c_CNT_W  = $clog2(c_MAX) + 1;

    localparam logic [c_CNT_W-1:0] c_STG_LD = c_CNT_W'(STAGE_DLY - 1);
    localparam logic [c_CNT_W-1:0] c_SET_LD = c_CNT_W'(SETTLE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_TO_LD  = c_CNT_W'(TIMEOUT_CYC - 1);

    localparam logic [2:0] c_OFF      = 3'd0;
    localparam logic [2:0] c_RAMP_UP  = 3'd1;
    localparam logic [2:0] c_WAIT_ACK = 3'd2;
    localparam logic [2:0] c_SETTLE   = 3'd3;
    localparam logic [2:0] c_DEISO    = 3'd4;
    localparam logic [2:0] c_ON       = 3'd5;
    localparam logic [2:0] c_ISO      = 3'd6;

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [NSTAGE-1:0]  r_sw_en;
    logic               w_cnt_zero;
    logic [NSTAGE-1:0]  w_sw_next;

    assign w_cnt_zero = (r_cnt == '0);
    // The enables form a thermometer code, so OR-ing in a left shift adds
    // exactly the next-higher segment.
    assign w_sw_next  = r_sw_en | (r_sw_en << 1);

    // Sequencer state, shared down-counter and switch enables.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_OFF;
            r_cnt   <= '0;
            r_sw_en <= '0;
        end else begin
            case (r_state)
                c_OFF: begin
                    if (pwr_on_req_i) begin
                        r_state <= c_RAMP_UP;
                        r_sw_en <= NSTAGE'(1);
                        r_cnt   <= c_STG_LD;
                    end
                end
                c_RAMP_UP: begin
                    if (!pwr_on_req_i) begin
                        r_state <= c_ISO;
                    end else if (w_cnt_zero) begin
                        if (&r_sw_en) begin
                            r_state <= c_WAIT_ACK;
                            r_cnt   <= c_TO_LD;
                        end else begin
                            r_sw_en <= w_sw_next;
                            r_cnt   <= c_STG_LD;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_WAIT_ACK: begin
                    if (!pwr_on_req_i) begin
                        r_state <= c_ISO;
                    end else if (sw_ack_i) begin
                        r_state <= c_SETTLE;
                        r_cnt   <= c_SET_LD;
`ifdef CGRA_PWR_SEQ_TIMEOUT_EN
                    end else if (w_cnt_zero) begin
                        // Ack never came: proceed anyway, error flag records it.
                        r_state <= c_SETTLE;
                        r_cnt   <= c_SET_LD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
`endif
                    end
                end
                c_SETTLE: begin
                    if (!pwr_on_req_i) begin
                        r_state <= c_ISO;
                    end else if (w_cnt_zero) begin
                        r_state <= c_DEISO;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_DEISO: begin
                    if (!pwr_on_req_i) begin
                        r_state <= c_ISO;
                    end else begin
                        r_state <= c_ON;
                    end
                end
                c_ON: begin
                    // Ack dropping here is deliberately ignored.
                    if (!pwr_on_req_i) begin
                        r_state <= c_ISO;
                    end
                end
                c_ISO: begin
                    // Request is not looked at here, guaranteeing one OFF cycle.
                    r_state <= c_OFF;
                    r_sw_en <= '0;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= c_OFF;
                    r_sw_en <= '0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef CGRA_PWR_SEQ_TIMEOUT_EN
    logic r_err;

    // Sticky timeout flag, set on the edge that abandons the ack wait.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if ((r_state == c_WAIT_ACK) && pwr_on_req_i && !sw_ack_i && w_cnt_zero) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

    // Isolation is released only in DEISO/ON, which are reachable only with
    // the whole chain enabled.
    assign sw_en_o   = r_sw_en;
    assign iso_o     = !((r_state == c_DEISO) || (r_state == c_ON));
    assign pwr_ack_o = (r_state == c_ON);

endmodule
`default_nettype wire

// File: doc/cgra_pwr_seq.md
CGRA_PWR_SEQ -- requirements
Module: cgra_pwr_seq

Interface
REQ-001 SHALL have parameter NSTAGE, default 4: number of power-switch chain segments, range 1..8.
REQ-002 SHALL have parameter STAGE_DLY, default 3: cycles between consecutive segment enables, range >=1.
REQ-003 SHALL have parameter SETTLE_CYC, default 2: cycles of rail settling after chain ack, range >=1.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 64: cycles allowed in WAIT_ACK, range >=1; used only under CGRA_PWR_SEQ_TIMEOUT_EN.
REQ-005 SHALL have port clk_i, input, 1: single clock.
REQ-006 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port pwr_on_req_i, input, 1: CGRA power domain requested on; driven by the MCU power controller.
REQ-008 SHALL have port sw_en_o, output, NSTAGE: per-segment power-switch enables.
REQ-009 SHALL have port sw_ack_i, input, 1: end-of-chain acknowledgement from the physical switch.
REQ-010 SHALL have port iso_o, output, 1: isolation enable for CGRA outputs; 1 = isolated.
REQ-011 SHALL have port pwr_ack_o, output, 1: domain on and de-isolated; returned to the MCU power controller.
REQ-012 SHALL have port err_o, output, 1: sticky chain-ack timeout flag.

Function
REQ-013 SHALL implement states OFF, RAMP_UP, WAIT_ACK, SETTLE, DEISO, ON and ISO, with one down-counter shared by the timed states.
REQ-014 SHALL hold OFF with sw_en_o=0, iso_o=1 and pwr_ack_o=0, and leave OFF at edge E, the first edge sampling pwr_on_req_i=1, into RAMP_UP with sw_en_o=1 (bit 0 only).
REQ-015 SHALL, in RAMP_UP, set the next-higher sw_en_o bit every STAGE_DLY edges (bit k set after edge E+k*STAGE_DLY), never clearing a bit.
REQ-016 SHALL enter WAIT_ACK after edge E+NSTAGE*STAGE_DLY with all sw_en_o bits set.
REQ-017 SHALL, in WAIT_ACK, move to SETTLE on the first edge sampling sw_ack_i=1.
REQ-018 SHALL stay SETTLE_CYC cycles in SETTLE, then enter DEISO with iso_o=0 and pwr_ack_o=0.
REQ-019 SHALL go from DEISO to ON after exactly one cycle, setting pwr_ack_o=1; iso_o SHALL never be 0 while any sw_en_o bit is 0.
REQ-020 SHALL, in ON, move to ISO on an edge sampling pwr_on_req_i=0, with iso_o=1 and pwr_ack_o=0 after that edge.
REQ-021 SHALL go from ISO to OFF after one cycle, clearing all sw_en_o bits at once.
REQ-022 SHALL, if pwr_on_req_i is sampled 0 in RAMP_UP, WAIT_ACK, SETTLE or DEISO, go to ISO at that edge (abort), then to OFF.
REQ-023 SHALL ignore pwr_on_req_i=1 in ISO; OFF re-evaluates it on the next edge, giving a minimum of one OFF cycle.
REQ-024 SHALL, in ON, ignore sw_ack_i dropping.
REQ-025 SHALL size the counter to $clog2 of the largest of STAGE_DLY, SETTLE_CYC and TIMEOUT_CYC, plus 1, with no wrap-around reachable.

Reset
REQ-026 SHALL, on an edge sampling rst_i=1 in any state (including mid-ramp), enter OFF with sw_en_o=0, iso_o=1, pwr_ack_o=0, err_o=0 and counter=0.
REQ-027 SHALL give rst_i priority over every other input.

Configuration
REQ-028 SHALL, with CGRA_PWR_SEQ_TIMEOUT_EN defined, leave WAIT_ACK after TIMEOUT_CYC cycles without sw_ack_i=1, set err_o (sticky until reset) and proceed to SETTLE.
REQ-029 SHALL, without CGRA_PWR_SEQ_TIMEOUT_EN, wait in WAIT_ACK indefinitely, tie err_o to 0 and leave TIMEOUT_CYC unused.

Verification (NSTAGE=4, STAGE_DLY=3, SETTLE_CYC=2, TIMEOUT_CYC=8)
REQ-030 SHALL cover power-up: sw_ack_i=1, pwr_on_req_i rises at edge E -> sw_en_o 0001/0011/0111/1111 after E, E+3, E+6, E+9; iso_o=0 after E+15; pwr_ack_o=1 after E+16.
REQ-031 SHALL cover power-down: in ON, drop pwr_on_req_i at edge F -> after F iso_o=1 and pwr_ack_o=0; after F+1 sw_en_o=0000.
REQ-032 SHALL cover abort: drop pwr_on_req_i at E+5 -> ISO after E+5 with sw_en_o=0011 held; OFF with sw_en_o=0000 after E+6; pwr_ack_o stays 0 throughout.
REQ-033 SHALL cover timeout with macro: sw_ack_i=0 -> err_o=1 after WAIT_ACK plus 8 cycles, then pwr_ack_o=1 three cycles later; without macro, stays in WAIT_ACK and err_o=0.
REQ-034 SHALL cover reset mid-ramp: rst_i=1 at E+7 -> outputs at reset values after E+7; with pwr_on_req_i held 1, the ramp restarts from sw_en_o=0001 at the first edge after rst_i falls.
